// File: rtl/pushbutton_pkg.sv
// Shared types and defaults for the pushbutton conditioning stage.
package pushbutton_pkg;

  // Per-channel debounce FSM; Gray-ordered so each legal step flips one bit.
  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b11,
    RELEASE_WAIT = 2'b10
  } btn_state_t;

  // 5 ms at 50 MHz.
  localparam int unsigned DEBOUNCE_DEFAULT = 250000;

endpackage : pushbutton_pkg

// File: rtl/btn_debounce_ch.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM with a
// saturating sample counter, and registered level/press/release outputs.
module btn_debounce_ch
  import pushbutton_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit          INVERT_IN       = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Two-stage synchronizer; polarity is fixed before the first flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw ^ INVERT_IN;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: a WAIT state needs DEBOUNCE_CYCLES consecutive
  // samples of the new level; any reversal falls back and clears the count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule : btn_debounce_ch

// File: rtl/pushbutton_conditioner.sv
// Pushbutton conditioning stage: N_BTN independent debounced channels
// feeding the processor's pushbuttons input.
module pushbutton_conditioner
  import pushbutton_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit          INVERT_IN       = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT_IN      (INVERT_IN)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule : pushbutton_conditioner

// File: tb/tb_pushbutton_conditioner.sv
// Bench for pushbutton_conditioner with DEBOUNCE_CYCLES=4: directed vector
// table, a reset-mid-count sequence, then random stimulus against a model.
module tb_pushbutton_conditioner;

  localparam int unsigned DB = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] raw0, raw1;
  logic [3:0] lvl0, prs0, rel0;
  logic [3:0] lvl1, prs1, rel1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pushbutton_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(DB), .INVERT_IN(1'b0)
  ) dut0 (
    .clock(clk), .reset(rst_n), .btn_raw(raw0),
    .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0)
  );

  pushbutton_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(DB), .INVERT_IN(1'b1)
  ) dut1 (
    .clock(clk), .reset(rst_n), .btn_raw(raw1),
    .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: two-sample delay line, then a level flips once DB
  // consecutive delayed samples disagree with it.
  logic [3:0]  m_p1  [2];
  logic [3:0]  m_p2  [2];
  logic [3:0]  m_lvl [2];
  logic [3:0]  m_prs [2];
  logic [3:0]  m_rel [2];
  int unsigned m_run [2][4];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_p1[k] = '0; m_p2[k] = '0; m_lvl[k] = '0; m_prs[k] = '0; m_rel[k] = '0;
      for (int c = 0; c < 4; c++) m_run[k][c] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] in_now;
    for (int k = 0; k < 2; k++) begin
      in_now = (k == 0) ? raw0 : ~raw1;
      m_prs[k] = '0;
      m_rel[k] = '0;
      for (int c = 0; c < 4; c++) begin
        if (m_p2[k][c] != m_lvl[k][c]) begin
          m_run[k][c] = m_run[k][c] + 1;
          if (m_run[k][c] == DB) begin
            m_lvl[k][c] = m_p2[k][c];
            m_run[k][c] = 0;
            if (m_p2[k][c]) m_prs[k][c] = 1'b1;
            else            m_rel[k][c] = 1'b1;
          end
        end else begin
          m_run[k][c] = 0;
        end
      end
      m_p2[k] = m_p1[k];
      m_p1[k] = in_now;
    end
  endtask

  // Advance one clock; the model follows the same edge; sample 1 ns later.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge();
      #1;
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out0(input string tag, input logic [3:0] l,
                            input logic [3:0] p, input logic [3:0] r);
    check({tag, ".level"},   lvl0, l);
    check({tag, ".press"},   prs0, p);
    check({tag, ".release"}, rel0, r);
  endtask

  typedef struct {
    logic [3:0]  raw;
    int unsigned edges;
    logic [3:0]  lvl;
    logic [3:0]  prs;
    logic [3:0]  rel;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] raw, input int unsigned edges,
                     input logic [3:0] l, input logic [3:0] p, input logic [3:0] r);
    vec_t v;
    v.raw = raw; v.edges = edges; v.lvl = l; v.prs = p; v.rel = r;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] flip;
    int unsigned rst_hold;

    // Clean press: first edge sampling high is edge 0; accept after edge 5.
    add(4'b0001, 5, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 1, 4'b0001, 4'b0001, 4'b0000);
    add(4'b0001, 1, 4'b0001, 4'b0000, 4'b0000);
    // Bounce on channel 1 while channel 0 is held.
    add(4'b0011, 1, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0001, 1, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0011, 1, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0001, 1, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0001, 4, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0001, 6, 4'b0001, 4'b0000, 4'b0000);
    // Clean release: 6 edges.
    add(4'b0000, 5, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
    // 3-clock pulse is rejected.
    add(4'b0100, 3, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 8, 4'b0000, 4'b0000, 4'b0000);
    // 4-clock pulse is the shortest accepted: press then release.
    add(4'b0100, 4, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 2, 4'b0100, 4'b0100, 4'b0000);
    add(4'b0000, 3, 4'b0100, 4'b0000, 4'b0000);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
    // Simultaneous press and release on channels 1 and 3.
    add(4'b1010, 5, 4'b0000, 4'b0000, 4'b0000);
    add(4'b1010, 1, 4'b1010, 4'b1010, 4'b0000);
    add(4'b1010, 1, 4'b1010, 4'b0000, 4'b0000);
    add(4'b0000, 5, 4'b1010, 4'b0000, 4'b0000);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b1010);
    add(4'b0000, 2, 4'b0000, 4'b0000, 4'b0000);
    // Single-sample reversal in PRESS_WAIT restarts the full count.
    add(4'b0001, 3, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 5, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 1, 4'b0001, 4'b0001, 4'b0000);
    add(4'b0000, 5, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0000, 3, 4'b0000, 4'b0000, 4'b0000);

    // Reset with the inverted-instance button already held.
    rst_n = 1'b0;
    raw0  = 4'b0000;
    raw1  = 4'b1110;
    model_reset();
    step(3);
    check_out0("reset", 4'b0000, 4'b0000, 4'b0000);
    check("reset.inv.level", lvl1, 4'b0000);
    rst_n = 1'b1;

    // Inverted input: 1110 held reads as channel 0 pressed.
    step(5);
    check("inv.level.e4", lvl1, 4'b0000);
    step(1);
    check("inv.level.e5", lvl1, 4'b0001);
    check("inv.press.e5", prs1, 4'b0001);
    step(1);
    check("inv.press.e6", prs1, 4'b0000);

    foreach (tbl[i]) begin
      raw0 = tbl[i].raw;
      step(tbl[i].edges);
      check_out0($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rel);
    end

    // Reset mid-count: channel 0 pressed, channel 2 counting, held through reset.
    raw0 = 4'b0001;
    step(8);
    check_out0("pre_rst", 4'b0001, 4'b0000, 4'b0000);
    raw0 = 4'b0101;
    step(4);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_out0("in_rst.now", 4'b0000, 4'b0000, 4'b0000);
    step(2);
    check_out0("in_rst.2", 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    step(5);
    check_out0("post_rst.5", 4'b0000, 4'b0000, 4'b0000);
    step(1);
    check_out0("post_rst.6", 4'b0101, 4'b0101, 4'b0000);

    // Random bouncing inputs with occasional asynchronous resets.
    rst_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        flip = '0;
        for (int c = 0; c < 4; c++)
          if ($urandom_range(7) == 0) flip[c] = 1'b1;
        if (k == 0) raw0 = raw0 ^ flip;
        else        raw1 = raw1 ^ flip;
      end
      if (!rst_n) begin
        if (rst_hold == 0) rst_n = 1'b1;
        else rst_hold--;
      end else if ($urandom_range(399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        rst_hold = $urandom_range(2);
      end
      step(1);
      check("rnd.level0",   lvl0, m_lvl[0]);
      check("rnd.press0",   prs0, m_prs[0]);
      check("rnd.release0", rel0, m_rel[0]);
      check("rnd.level1",   lvl1, m_lvl[1]);
      check("rnd.press1",   prs1, m_prs[1]);
      check("rnd.release1", rel1, m_rel[1]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pushbutton_conditioner

// File: doc/pushbutton_conditioner.md
# pushbutton_conditioner

Input-side conditioning stage for the 4-bit processor. It synchronizes the raw board pushbuttons to `clock`, debounces each one independently, and drives the clean levels straight into the processor's `pushbuttons` input. The processor's input bus driver then samples these levels onto the data bus. The block also gives one-cycle press and release pulses for status LEDs and test observation.

## Interface
Parameters:
- `N_BTN`, 4: number of buttons; must be 4 when driving the processor.
- `DEBOUNCE_CYCLES`, 250000: consecutive synchronized samples needed to accept a new level (5 ms at 50 MHz). Legal range is 2 or more.
- `INVERT_IN`, 0: when 1, `btn_raw` is inverted before synchronization (for active-low boards).

Ports:
- `clock`  in  1  single system clock; all flops on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  N_BTN  raw, asynchronous, bouncing pushbutton pins.
- `btn_level`  out  N_BTN  debounced level; connects to the processor's `pushbuttons`.
- `btn_press`  out  N_BTN  one-cycle pulse when the debounced level goes 0→1.
- `btn_release`  out  N_BTN  one-cycle pulse when the debounced level goes 1→0.

## Operation
- Each channel is independent and identical.
- **Synchronizer:** 2-flop chain per bit, producing `s`. `INVERT_IN` is applied before the first flop.
- **Per-channel FSM states:** RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- **Per-channel counter:** `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`. It saturates and is never allowed to wrap.
- **Transitions, evaluated each edge:**
  - RELEASED, s=1: go to PRESS_WAIT, cnt=1. RELEASED, s=0: stay, cnt=0.
  - PRESS_WAIT, s=0: go to RELEASED, cnt=0, no pulse (glitch rejected).
  - PRESS_WAIT, s=1, cnt<DEBOUNCE_CYCLES-1: cnt++.
  - PRESS_WAIT, s=1, cnt==DEBOUNCE_CYCLES-1: go to PRESSED, cnt=0, `btn_level`←1, `btn_press`←1 for one cycle.
  - PRESSED and RELEASE_WAIT mirror the above with the polarity swapped. Their exit to RELEASED drives `btn_level`←0 and `btn_release`←1 for one cycle.
- **Outputs:** `btn_level`, `btn_press` and `btn_release` are registered, with no combinational path from `btn_raw`.
- **Pulse exclusivity:** `btn_press` and `btn_release` never assert together on one channel. Pulses on different channels may coincide.

## Timing
- **Reset:** asserting `reset` (low) immediately clears the sync flops, the counters, `btn_level`, `btn_press` and `btn_release` to 0. All FSMs go to RELEASED.
- **Reset mid-operation:** a partial count is discarded.
- **Button held through reset:** after deassertion it is debounced from scratch and produces a normal `btn_press`.
- **Press latency:** `btn_level` and `btn_press` rise after the (DEBOUNCE_CYCLES+2)-th rising edge, counted from the first edge that samples `btn_raw` high.
  - This applies only if the raw input stays high throughout.
  - Release latency is identical.
- **Pulse width:** `btn_press` and `btn_release` are exactly one clock wide.
- **Minimum accepted pulse:** a raw pulse shorter than DEBOUNCE_CYCLES clocks (after synchronization) produces no output change.
- **Re-triggering:** any single-sample reversal during a WAIT state restarts the full count.
- **Simultaneous events:** presses on several channels in the same cycle each complete independently, with identical latency.
- **Processor sampling:** the processor sees the level change on `pushbuttons` in the cycle after `btn_level` updates (registered boundary). No handshake exists; the processor polls.

## Structure
- **Shared package `pushbutton_pkg`:**
  - typedef `btn_state_t`, a 2-bit enum: RELEASED=00, PRESS_WAIT=01, PRESSED=11, RELEASE_WAIT=10.
  - A default constant `DEBOUNCE_DEFAULT = 250000`.
- **Sub-module `btn_debounce_ch`:** one channel, containing the synchronizer, FSM, counter and output registers. It takes `DEBOUNCE_CYCLES` and `INVERT_IN` as parameters.
- **Top level:** `pushbutton_conditioner` instantiates `btn_debounce_ch` N_BTN times in a generate loop. There is no other logic at the top level.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `INVERT_IN=0`.
- **Clean press:** `btn_raw`=0001 at edge 0, held → `btn_level`[0]=1 and `btn_press`[0]=1 after edge 5; `btn_press`[0]=0 after edge 6; other bits stay 0.
- **Bounce rejection:** `btn_raw`[1] toggles 1,0,1,0 on consecutive edges, then holds 0 → `btn_level`=0000 and no pulses; the channel-1 FSM returns to RELEASED.
- **Clean release:** from `btn_level`=0001, `btn_raw`=0000 held → `btn_level`[0]=0 and `btn_release`[0]=1 exactly 6 edges later, one cycle wide.
- **Simultaneous presses:** `btn_raw`=1010 at edge 0 → `btn_level`=1010 and `btn_press`=1010 together after edge 5.
- **Reset mid-count:** `btn_raw`=0100 held; pull `reset` low after edge 3 and release it 2 cycles later → all outputs read 0 during reset. `btn_press`[2] fires 6 edges after reset is released.
- **Inverted input:** with `INVERT_IN=1`, `btn_raw`=1110 held from reset → `btn_level`=0001 after 6 edges.
